// File: rtl/eth_writer.sv
// Builds one fixed 98-byte Ethernet/IPv4/UDP status frame from a snapshot of
// the field inputs and streams it on an 8-bit LocalLink TX port (FCS added by the MAC).
module eth_writer #(
  parameter logic [31:0] IDENT  = 32'hDEADBEEF,
  parameter logic [7:0]  IP_TTL = 8'h40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [7:0]  gen_numChannels,
  input  logic [7:0]  gen_spare0,
  input  logic [7:0]  gen_spare1,
  input  logic [7:0]  gen_spare2,
  input  logic [31:0] ch0_threshold,
  input  logic [7:0]  ch0_fftSize,
  input  logic [7:0]  ch0_mode,
  input  logic [31:0] ch0_frequency,
  input  logic [7:0]  ch0_spare0,
  input  logic [7:0]  ch0_spare1,
  input  logic [31:0] ch1_threshold,
  input  logic [7:0]  ch1_fftSize,
  input  logic [7:0]  ch1_mode,
  input  logic [31:0] ch1_frequency,
  input  logic [7:0]  ch1_spare0,
  input  logic [7:0]  ch1_spare1,
  input  logic [31:0] ch2_threshold,
  input  logic [7:0]  ch2_fftSize,
  input  logic [7:0]  ch2_mode,
  input  logic [31:0] ch2_frequency,
  input  logic [7:0]  ch2_spare0,
  input  logic [7:0]  ch2_spare1,
  input  logic [31:0] ch3_threshold,
  input  logic [7:0]  ch3_fftSize,
  input  logic [7:0]  ch3_mode,
  input  logic [31:0] ch3_frequency,
  input  logic [7:0]  ch3_spare0,
  input  logic [7:0]  ch3_spare1,
  output logic [7:0]  data_out,
  output logic        sof_n,
  output logic        eof_n,
  output logic        src_rdy_n,
  input  logic        dst_rdy_n,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CSUM, FOLD, SEND} state_t;

  state_t state, state_next;

  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q;
  logic [31:0] gen_q;
  logic [95:0] ch_q [4];

  logic [6:0]   cnt;
  logic [19:0]  acc;
  logic [19:0]  fold;
  logic [15:0]  csum_q;
  logic [15:0]  csum_word;
  logic [783:0] frame;
  logic [6:0]   next_idx;
  logic [6:0]   rev_idx;
  logic [9:0]   bit_lo;
  logic [7:0]   next_byte;
  logic         xfer;
  logic         accept;

  assign xfer   = !src_rdy_n && !dst_rdy_n;
  assign accept = (state == IDLE) && send;

  // NOTE: these are pure data registers, always loaded before they are read,
  // so they carry no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_mac_q  <= dst_mac;
      src_mac_q  <= src_mac;
      src_ip_q   <= src_ip;
      dst_ip_q   <= dst_ip;
      src_port_q <= src_port;
      dst_port_q <= dst_port;
      gen_q      <= {gen_numChannels, gen_spare0, gen_spare1, gen_spare2};
      ch_q[0]    <= {ch0_threshold, ch0_fftSize, ch0_mode, ch0_frequency, ch0_spare0, ch0_spare1};
      ch_q[1]    <= {ch1_threshold, ch1_fftSize, ch1_mode, ch1_frequency, ch1_spare0, ch1_spare1};
      ch_q[2]    <= {ch2_threshold, ch2_fftSize, ch2_mode, ch2_frequency, ch2_spare0, ch2_spare1};
      ch_q[3]    <= {ch3_threshold, ch3_fftSize, ch3_mode, ch3_frequency, ch3_spare0, ch3_spare1};
    end
  end

  // Whole frame, byte 0 in the top bits; checksum slot reads csum_q.
  assign frame = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, 16'h0054,
                  16'h0000, 16'h4000, IP_TTL, 8'h11, csum_q,
                  src_ip_q, dst_ip_q, src_port_q, dst_port_q,
                  16'h0040, 16'h0000, IDENT, gen_q,
                  ch_q[0], ch_q[1], ch_q[2], ch_q[3]};

  assign next_idx  = (state == SEND) ? cnt + 7'd1 : 7'd0;
  assign rev_idx   = (next_idx <= 7'd97) ? 7'd97 - next_idx : 7'd0;
  assign bit_lo    = {rev_idx, 3'b000};
  assign next_byte = frame[bit_lo +: 8];

  assign fold = {4'b0000, acc[15:0]} + {16'h0000, acc[19:16]};

  always_comb begin
    case (cnt[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = 16'h0054;
      4'd2:    csum_word = 16'h0000;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {IP_TTL, 8'h11};
      4'd5:    csum_word = src_ip_q[31:16];
      4'd6:    csum_word = src_ip_q[15:0];
      4'd7:    csum_word = dst_ip_q[31:16];
      default: csum_word = dst_ip_q[15:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (send)                    state_next = CSUM;
      CSUM: if (cnt == 7'd8)             state_next = FOLD;
      FOLD: if (cnt == 7'd1)             state_next = SEND;
      SEND: if (xfer && cnt == 7'd97)    state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      csum_q    <= '0;
      data_out  <= '0;
      sof_n     <= 1'b1;
      eof_n     <= 1'b1;
      src_rdy_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            busy <= 1'b1;
            cnt  <= '0;
            acc  <= '0;
          end
        end
        CSUM: begin
          acc <= acc + {4'b0000, csum_word};
          cnt <= (cnt == 7'd8) ? 7'd0 : cnt + 7'd1;
        end
        FOLD: begin
          acc <= fold;
          if (cnt == 7'd1) begin
            csum_q    <= ~fold[15:0];
            cnt       <= '0;
            data_out  <= next_byte;
            sof_n     <= 1'b0;
            eof_n     <= 1'b1;
            src_rdy_n <= 1'b0;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        SEND: begin
          // Outputs only move on a transfer, so backpressure holds them.
          if (xfer) begin
            if (cnt == 7'd97) begin
              src_rdy_n <= 1'b1;
              sof_n     <= 1'b1;
              eof_n     <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              cnt      <= cnt + 7'd1;
              data_out <= next_byte;
              sof_n    <= 1'b1;
              eof_n    <= (cnt != 7'd96);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_writer.sv
// Scoreboard bench for eth_writer: stimulus pushes expected bytes, a negedge
// monitor pops and compares on every LocalLink transfer.
module tb_eth_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic        dst_rdy_n = 1'b0;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] src_port, dst_port;
  logic [7:0]  gen_num, gen_sp0, gen_sp1, gen_sp2;
  logic [31:0] ch_thr  [4];
  logic [7:0]  ch_fft  [4];
  logic [7:0]  ch_mode [4];
  logic [31:0] ch_freq [4];
  logic [7:0]  ch_sp0  [4];
  logic [7:0]  ch_sp1  [4];
  logic [7:0]  data_out;
  logic        sof_n, eof_n, src_rdy_n, busy, done;

  int n_vec = 0;
  int n_err = 0;
  int xfer_total = 0;
  int fidx = 0;
  logic [9:0] exp_q [$];
  logic [7:0] fb [$];
  logic [7:0] rx [98];
  logic       stalled = 1'b0;
  logic [9:0] held;

  always #5 clk = ~clk;

  eth_writer dut (
    .clk(clk), .rst_n(rst_n), .send(send),
    .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip), .dst_ip(dst_ip),
    .src_port(src_port), .dst_port(dst_port),
    .gen_numChannels(gen_num), .gen_spare0(gen_sp0), .gen_spare1(gen_sp1), .gen_spare2(gen_sp2),
    .ch0_threshold(ch_thr[0]), .ch0_fftSize(ch_fft[0]), .ch0_mode(ch_mode[0]),
    .ch0_frequency(ch_freq[0]), .ch0_spare0(ch_sp0[0]), .ch0_spare1(ch_sp1[0]),
    .ch1_threshold(ch_thr[1]), .ch1_fftSize(ch_fft[1]), .ch1_mode(ch_mode[1]),
    .ch1_frequency(ch_freq[1]), .ch1_spare0(ch_sp0[1]), .ch1_spare1(ch_sp1[1]),
    .ch2_threshold(ch_thr[2]), .ch2_fftSize(ch_fft[2]), .ch2_mode(ch_mode[2]),
    .ch2_frequency(ch_freq[2]), .ch2_spare0(ch_sp0[2]), .ch2_spare1(ch_sp1[2]),
    .ch3_threshold(ch_thr[3]), .ch3_fftSize(ch_fft[3]), .ch3_mode(ch_mode[3]),
    .ch3_frequency(ch_freq[3]), .ch3_spare0(ch_sp0[3]), .ch3_spare1(ch_sp1[3]),
    .data_out(data_out), .sof_n(sof_n), .eof_n(eof_n), .src_rdy_n(src_rdy_n),
    .dst_rdy_n(dst_rdy_n), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when both ready lines are low.
  always @(negedge clk) begin
    if (rst_n && !src_rdy_n) begin
      if (stalled) check("hold_stable", {sof_n, eof_n, data_out}, held);
      if (!dst_rdy_n) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_xfer: got byte %0h with no frame expected", data_out);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (!e[9]) fidx = 0;
          check($sformatf("byte%0d", fidx), {sof_n, eof_n, data_out}, e);
          if (fidx < 98) rx[fidx] = data_out;
          fidx++;
        end
        xfer_total++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {sof_n, eof_n, data_out};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic add(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[i*8 +: 8]);
  endtask

  // Expected-frame model built field by field from the current inputs.
  task automatic push_frame();
    logic [31:0] s;
    logic [15:0] ck;
    s = 32'h4500 + 32'h0054 + 32'h4000 + 32'h4011
      + {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]}
      + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    ck = ~s[15:0];
    fb.delete();
    add(dst_mac, 6); add(src_mac, 6); add(64'h0800, 2); add(64'h45, 1); add(64'h00, 1);
    add(64'h0054, 2); add(64'h0000, 2); add(64'h4000, 2); add(64'h40, 1); add(64'h11, 1);
    add(ck, 2); add(src_ip, 4); add(dst_ip, 4); add(src_port, 2); add(dst_port, 2);
    add(64'h0040, 2); add(64'h0000, 2); add(64'hDEADBEEF, 4);
    add(gen_num, 1); add(gen_sp0, 1); add(gen_sp1, 1); add(gen_sp2, 1);
    for (int c = 0; c < 4; c++) begin
      add(ch_thr[c], 4); add(ch_fft[c], 1); add(ch_mode[c], 1);
      add(ch_freq[c], 4); add(ch_sp0[c], 1); add(ch_sp1[c], 1);
    end
    for (int i = 0; i < 98; i++) exp_q.push_back({i != 0, i != 97, fb[i]});
  endtask

  task automatic set_vector();
    dst_mac = 48'h001122334455; src_mac = 48'h0A0B0C0D0E0F;
    src_ip = 32'hC0A8010A; dst_ip = 32'hC0A80101;
    src_port = 16'h1234; dst_port = 16'h5678;
    gen_num = 8'h04; gen_sp0 = 8'hA0; gen_sp1 = 8'hA1; gen_sp2 = 8'hA2;
    for (int c = 0; c < 4; c++) begin
      ch_thr[c]  = 32'h01010101 * (c + 1);
      ch_fft[c]  = 8'h10 + 8'(c);
      ch_mode[c] = 8'h20 + 8'(c);
      ch_freq[c] = 32'h10203040 + 32'(c);
      ch_sp0[c]  = 8'h30 + 8'(c);
      ch_sp1[c]  = 8'h40 + 8'(c);
    end
    ch_thr[2] = 32'h11223344; ch_freq[2] = 32'hAABBCCDD;
    ch_fft[2] = 8'h0A;        ch_mode[2] = 8'h03;
  endtask

  task automatic scramble();
    dst_mac = ~dst_mac; src_mac = ~src_mac; src_ip = ~src_ip; dst_ip = ~dst_ip;
    src_port = ~src_port; dst_port = ~dst_port;
    gen_num = ~gen_num; gen_sp0 = ~gen_sp0; gen_sp1 = ~gen_sp1; gen_sp2 = ~gen_sp2;
    for (int c = 0; c < 4; c++) begin
      ch_thr[c] = ~ch_thr[c]; ch_fft[c] = ~ch_fft[c]; ch_mode[c] = ~ch_mode[c];
      ch_freq[c] = ~ch_freq[c]; ch_sp0[c] = ~ch_sp0[c]; ch_sp1[c] = ~ch_sp1[c];
    end
  endtask

  // Issues one frame. bp stalls 5 cycles at bytes 0/50/97, chg scrambles inputs
  // and re-pulses send mid-frame, rst_at >= 0 resets with that byte on the bus.
  // Returns at +1 after the edge where done rises (or after the reset).
  task automatic run_frame(input bit bp, input bit chg, input int rst_at);
    int base, idx, stall_left;
    bit seen_valid, chg_done, got_done;
    bit [2:0] used;
    push_frame();
    base = xfer_total;
    stall_left = 0; seen_valid = 0; chg_done = 0; got_done = 0; used = '0;
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      send = 1'b0;
      idx = xfer_total - base;
      if (done) begin
        got_done = 1;
        break;
      end
      if (!seen_valid && !src_rdy_n) begin
        check("first_byte_latency", k, 11);
        seen_valid = 1;
      end
      if (chg && !chg_done && idx == 40) begin
        scramble();
        send = 1'b1;
        chg_done = 1;
      end
      if (rst_at >= 0 && idx == rst_at && seen_valid) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_src_rdy_n", src_rdy_n, 1'b1);
        check("rst_sof_n", sof_n, 1'b1);
        check("rst_eof_n", eof_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (stall_left > 0) begin
        stall_left--;
        dst_rdy_n = 1'b1;
      end else begin
        dst_rdy_n = 1'b0;
        if (bp && !src_rdy_n) begin
          if (idx == 0 && !used[0])  begin used[0] = 1; stall_left = 4; dst_rdy_n = 1'b1; end
          if (idx == 50 && !used[1]) begin used[1] = 1; stall_left = 4; dst_rdy_n = 1'b1; end
          if (idx == 97 && !used[2]) begin used[2] = 1; stall_left = 4; dst_rdy_n = 1'b1; end
        end
      end
    end
    dst_rdy_n = 1'b0;
    check("done_seen", got_done, 1'b1);
    check("transfers", xfer_total - base, 98);
    check("scoreboard_drained", exp_q.size(), 0);
    check("busy_at_done", busy, 1'b0);
    check("src_rdy_n_at_done", src_rdy_n, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vector();
    #12;
    check("reset_data_out", data_out, 8'h00);
    check("reset_sof_n", sof_n, 1'b1);
    check("reset_eof_n", eof_n, 1'b1);
    check("reset_src_rdy_n", src_rdy_n, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with the directed checksum/payload vector.
    run_frame(0, 0, -1);
    check("ip_csum_hi", rx[24], 8'hB7);
    check("ip_csum_lo", rx[25], 8'h3D);
    check("ident", {rx[42], rx[43], rx[44], rx[45]}, 32'hDEADBEEF);
    check("ch2_threshold", {rx[74], rx[75], rx[76], rx[77]}, 32'h11223344);
    check("ch2_fftsize", rx[78], 8'h0A);
    check("ch2_mode", rx[79], 8'h03);
    check("ch2_frequency", {rx[80], rx[81], rx[82], rx[83]}, 32'hAABBCCDD);
    @(posedge clk); #1;
    check("done_single_pulse", done, 1'b0);

    // Backpressure at bytes 0, 50 and 97.
    repeat (3) @(posedge clk);
    #1;
    run_frame(1, 0, -1);
    @(posedge clk); #1;

    // Inputs change and send pulses mid-frame: no effect, no second frame.
    run_frame(0, 1, -1);
    repeat (20) @(posedge clk);
    #1;
    check("no_second_frame", src_rdy_n, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Back-to-back: send during the done cycle starts the next frame.
    set_vector();
    src_ip = 32'h0A000001; dst_ip = 32'hFFFFFFFF;
    run_frame(0, 0, -1);
    run_frame(0, 0, -1);
    @(posedge clk); #1;

    // Reset with byte 30 on the bus, then a clean frame.
    run_frame(0, 0, 30);
    repeat (2) @(posedge clk);
    #1;
    set_vector();
    run_frame(1, 0, -1);
    check("ip_csum_after_reset", {rx[24], rx[25]}, 16'hB73D);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
